// File: rtl/buzzer_sequenciador_pkg.sv
// Shared state encoding and default timing for the buzzer beep sequencer.
// Defaults assume the 50 MHz board clock: 1 s on, 0.5 s off.
package buzzer_sequenciador_pkg;

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    LIGADO    = 2'd1,
    DESLIGADO = 2'd2,
    FIM       = 2'd3
  } estado_t;

  localparam int T_ON_PADRAO    = 50000000;
  localparam int T_OFF_PADRAO   = 25000000;
  localparam int W_CONT_PADRAO  = 26;
  localparam int W_BIPES_PADRAO = 4;

endpackage

// File: rtl/buzzer_sequenciador_temporizador_carga.sv
// Loadable down-counter: load wins, otherwise counts down and holds at zero.
// zero_o reflects the registered count, so expiry is seen one cycle after reaching 0.
module buzzer_sequenciador_temporizador_carga #(
  parameter int W_CONT = 26
) (
  input  logic              clock,
  input  logic              zera_n,
  input  logic              carga_i,
  input  logic [W_CONT-1:0] valor_i,
  output logic              zero_o
);

  logic [W_CONT-1:0] cont_q;
  logic [W_CONT-1:0] cont_d;

  always_comb begin
    cont_d = cont_q;
    if (carga_i) begin
      cont_d = valor_i;
    end else if (cont_q != '0) begin
      cont_d = cont_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge zera_n) begin
    if (!zera_n) begin
      cont_q <= '0;
    end else begin
      cont_q <= cont_d;
    end
  end

  assign zero_o = (cont_q == '0);

endmodule

// File: rtl/buzzer_sequenciador.sv
// Beep-pattern controller: N beeps of T_ON on / T_OFF off, driven as one-cycle
// liga/desliga pulses to a downstream set/clear buzzer latch. All outputs registered.
module buzzer_sequenciador
  import buzzer_sequenciador_pkg::*;
#(
  parameter int T_ON    = T_ON_PADRAO,
  parameter int T_OFF   = T_OFF_PADRAO,
  parameter int W_CONT  = W_CONT_PADRAO,
  parameter int W_BIPES = W_BIPES_PADRAO
) (
  input  logic               clock,
  input  logic               zera_n,
  input  logic               disparo,
  input  logic               cancela,
  input  logic [W_BIPES-1:0] num_bipes,
  output logic               liga,
  output logic               desliga,
  output logic               ocupado,
  output logic               fim
);

  localparam logic [W_CONT-1:0] CARGA_ON  = W_CONT'(T_ON - 1);
  localparam logic [W_CONT-1:0] CARGA_OFF = W_CONT'(T_OFF - 1);

  estado_t            state_q, state_d;
  logic [W_BIPES-1:0] restantes_q, restantes_d;
  logic               liga_q, liga_d;
  logic               desliga_q, desliga_d;
  logic               ocupado_q, ocupado_d;
  logic               fim_q, fim_d;
  logic               carga;
  logic [W_CONT-1:0]  valor_carga;
  logic               tempo_zero;

  buzzer_sequenciador_temporizador_carga #(
    .W_CONT (W_CONT)
  ) u_temporizador (
    .clock   (clock),
    .zera_n  (zera_n),
    .carga_i (carga),
    .valor_i (valor_carga),
    .zero_o  (tempo_zero)
  );

  always_comb begin
    state_d     = state_q;
    restantes_d = restantes_q;
    carga       = 1'b0;
    valor_carga = '0;
    liga_d      = 1'b0;
    desliga_d   = 1'b0;
    case (state_q)
      OCIOSO: begin
        if (disparo && (num_bipes != '0)) begin
          state_d     = LIGADO;
          restantes_d = num_bipes;
          carga       = 1'b1;
          valor_carga = CARGA_ON;
          liga_d      = 1'b1;
        end
      end
      LIGADO: begin
        // Abort takes priority over expiry so a cancel never leaves the buzzer on.
        if (cancela) begin
          state_d     = OCIOSO;
          restantes_d = '0;
          desliga_d   = 1'b1;
        end else if (tempo_zero) begin
          restantes_d = restantes_q - 1'b1;
          desliga_d   = 1'b1;
          if (restantes_q == W_BIPES'(1)) begin
            state_d = FIM;
          end else begin
            state_d     = DESLIGADO;
            carga       = 1'b1;
            valor_carga = CARGA_OFF;
          end
        end
      end
      DESLIGADO: begin
        if (cancela) begin
          state_d     = OCIOSO;
          restantes_d = '0;
          desliga_d   = 1'b1;
        end else if (tempo_zero) begin
          state_d     = LIGADO;
          carga       = 1'b1;
          valor_carga = CARGA_ON;
          liga_d      = 1'b1;
        end
      end
      FIM: begin
        state_d = OCIOSO;
      end
      default: begin
        state_d = OCIOSO;
      end
    endcase
    fim_d     = (state_d == FIM);
    ocupado_d = (state_d != OCIOSO);
  end

  always_ff @(posedge clock or negedge zera_n) begin
    if (!zera_n) begin
      state_q     <= OCIOSO;
      restantes_q <= '0;
      liga_q      <= 1'b0;
      desliga_q   <= 1'b0;
      ocupado_q   <= 1'b0;
      fim_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      restantes_q <= restantes_d;
      liga_q      <= liga_d;
      desliga_q   <= desliga_d;
      ocupado_q   <= ocupado_d;
      fim_q       <= fim_d;
    end
  end

  assign liga    = liga_q;
  assign desliga = desliga_q;
  assign ocupado = ocupado_q;
  assign fim     = fim_q;

endmodule

// File: tb/tb_buzzer_sequenciador.sv
// Bench for buzzer_sequenciador: directed scenarios plus random traffic against
// a schedule-based model (pulse times computed from start cycle and beep count).
module tb_buzzer_sequenciador;

  localparam int T_ON  = 4;
  localparam int T_OFF = 3;
  localparam int P     = T_ON + T_OFF;

  logic       clock;
  logic       zera_n;
  logic       disparo;
  logic       cancela;
  logic [3:0] num_bipes;
  logic       liga, desliga, ocupado, fim;

  int n_verif  = 0;
  int n_falhas = 0;

  // Reference model state: active pattern described by start cycle, beep count, end cycle.
  int t     = 0;
  int busy  = 0;
  int s_ini = 0;
  int n_bip = 0;
  int e_fim = 0;
  int exp_l, exp_d, exp_f, exp_o;

  buzzer_sequenciador #(
    .T_ON    (T_ON),
    .T_OFF   (T_OFF),
    .W_CONT  (4),
    .W_BIPES (4)
  ) dut (
    .clock     (clock),
    .zera_n    (zera_n),
    .disparo   (disparo),
    .cancela   (cancela),
    .num_bipes (num_bipes),
    .liga      (liga),
    .desliga   (desliga),
    .ocupado   (ocupado),
    .fim       (fim)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic verifica(input string tag, input int obs, input int esp);
    n_verif++;
    if (obs !== esp) begin
      n_falhas++;
      $display("FAIL %s (ciclo %0d): obtido %0d esperado %0d", tag, t, obs, esp);
    end
  endtask

  task automatic confere_saidas();
    verifica("liga",    int'(liga),    exp_l);
    verifica("desliga", int'(desliga), exp_d);
    verifica("fim",     int'(fim),     exp_f);
    verifica("ocupado", int'(ocupado), exp_o);
  endtask

  // One clock: apply inputs, advance the model over the edge, check the new outputs.
  task automatic ciclo(input logic d, input logic c, input logic [3:0] nb);
    int u, dd;
    disparo   = d;
    cancela   = c;
    num_bipes = nb;
    @(posedge clock);
    exp_l = 0; exp_d = 0; exp_f = 0; exp_o = 0;
    if (busy != 0 && t < e_fim && c) begin
      busy  = 0;
      exp_d = 1;
    end else begin
      if (busy != 0 && t == e_fim) begin
        busy = 0;
      end else if (busy == 0 && d && nb != 0) begin
        busy  = 1;
        s_ini = t + 1;
        n_bip = int'(nb);
        e_fim = s_ini + (n_bip - 1) * P + T_ON;
      end
      if (busy != 0) begin
        u     = t + 1;
        dd    = u - s_ini;
        exp_l = (dd % P == 0) ? 1 : 0;
        exp_d = (dd % P == T_ON) ? 1 : 0;
        exp_f = (u == e_fim) ? 1 : 0;
        exp_o = 1;
      end
    end
    t++;
    #1;
    confere_saidas();
  endtask

  task automatic ocioso(input int k);
    for (int i = 0; i < k; i++) ciclo(1'b0, 1'b0, 4'd0);
  endtask

  initial begin
    zera_n = 1'b0; disparo = 1'b0; cancela = 1'b0; num_bipes = 4'd0;
    #1;
    exp_l = 0; exp_d = 0; exp_f = 0; exp_o = 0;
    confere_saidas();
    repeat (2) @(posedge clock);
    @(negedge clock);
    zera_n = 1'b1;
    ocioso(2);

    // single beep
    ciclo(1'b1, 1'b0, 4'd1);
    ocioso(7);
    // three beeps
    ciclo(1'b1, 1'b0, 4'd3);
    ocioso(22);
    // zero beeps requested
    ciclo(1'b1, 1'b0, 4'd0);
    ocioso(3);
    // cancel during the second beep, then immediate restart
    ciclo(1'b1, 1'b0, 4'd3);
    ocioso(8);
    ciclo(1'b0, 1'b1, 4'd0);
    ciclo(1'b0, 1'b0, 4'd0);
    ciclo(1'b1, 1'b0, 4'd1);
    ocioso(7);
    // repeated disparo while busy
    ciclo(1'b1, 1'b0, 4'd1);
    ocioso(2);
    ciclo(1'b1, 1'b0, 4'd1);
    ocioso(2);
    ciclo(1'b1, 1'b0, 4'd2);
    ocioso(4);
    // cancela at the final FIM cycle must not suppress completion
    ciclo(1'b1, 1'b0, 4'd1);
    ocioso(4);
    ciclo(1'b0, 1'b1, 4'd0);
    ocioso(2);

    // asynchronous reset mid-beep
    ciclo(1'b1, 1'b0, 4'd2);
    ocioso(2);
    #2 zera_n = 1'b0;
    #1;
    exp_l = 0; exp_d = 0; exp_f = 0; exp_o = 0;
    confere_saidas();
    busy = 0;
    @(negedge clock);
    zera_n = 1'b1;
    ocioso(10);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      ciclo(($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
            4'($urandom_range(0, 3)));
    end
    ocioso(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_verif, n_falhas);
    $finish;
  end

endmodule
